// File: rtl/dft_bin_mag.sv
// Single-bin 32-point DFT magnitude estimator.
// Streams 32-sample chunks, emits |Re|+|Im| scaled and saturated per chunk.
module dft_bin_mag #(
    parameter int DATA_W = 12,
    parameter int OUT_W  = 15,
    parameter int BIN    = 2,
    parameter int TW_W   = 12,
    parameter int SHIFT  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready,
    output logic [OUT_W-1:0]  data_out,
    output logic              valid_out
);

    localparam int PROD_W = DATA_W + TW_W;
    localparam int ACC_W  = PROD_W + 6;
    localparam int SUM_W  = ACC_W + 2;
    localparam logic [4:0] BIN5 = 5'(BIN);

    typedef enum logic [1:0] {
        COLLECT,
        DRAIN,
        OUTPUT
    } state_t;

    state_t state, state_next;

    logic [4:0] idx;
    logic [1:0] dcnt;
    logic       accept;

    logic                     s1_v;
    logic                     s1_first;
    logic signed [DATA_W-1:0] s1_x;
    logic [4:0]               s1_n;

    logic                     s2_v;
    logic                     s2_first;
    logic signed [PROD_W-1:0] s2_re;
    logic signed [PROD_W-1:0] s2_im;

    logic signed [ACC_W-1:0]  acc_re;
    logic signed [ACC_W-1:0]  acc_im;
    logic [OUT_W-1:0]         mag_q;

    // Quarter-wave folded cosine table: round(1024*cos(2*pi*m/32)).
    function automatic logic signed [TW_W-1:0] cos_lut(input logic [4:0] m);
        logic [4:0]             f;
        logic                   neg;
        logic signed [TW_W-1:0] v;
        if (m <= 5'd8) begin
            f   = m;
            neg = 1'b0;
        end else if (m <= 5'd16) begin
            f   = 5'd16 - m;
            neg = 1'b1;
        end else if (m <= 5'd24) begin
            f   = m - 5'd16;
            neg = 1'b1;
        end else begin
            f   = 5'd0 - m;
            neg = 1'b0;
        end
        case (f)
            5'd0:    v = TW_W'(1024);
            5'd1:    v = TW_W'(1004);
            5'd2:    v = TW_W'(946);
            5'd3:    v = TW_W'(851);
            5'd4:    v = TW_W'(724);
            5'd5:    v = TW_W'(569);
            5'd6:    v = TW_W'(392);
            5'd7:    v = TW_W'(200);
            default: v = '0;
        endcase
        return neg ? -v : v;
    endfunction

    logic [4:0]               c_idx;
    logic [4:0]               s_idx;
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] c_ext;
    logic signed [PROD_W-1:0] s_ext;

    // sin(a) = cos(a - pi/2); a quarter turn is 8 table steps.
    always_comb begin
        c_idx = BIN5 * s1_n;
        s_idx = c_idx - 5'd8;
        x_ext = PROD_W'(s1_x);
        c_ext = PROD_W'(cos_lut(c_idx));
        s_ext = PROD_W'(cos_lut(s_idx));
    end

    logic signed [ACC_W:0] re_w;
    logic signed [ACC_W:0] im_w;
    logic [ACC_W:0]        abs_re;
    logic [ACC_W:0]        abs_im;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      shifted;
    logic [OUT_W-1:0]      mag_sat;

    always_comb begin
        re_w    = {acc_re[ACC_W-1], acc_re};
        im_w    = {acc_im[ACC_W-1], acc_im};
        abs_re  = re_w[ACC_W] ? $unsigned(-re_w) : $unsigned(re_w);
        abs_im  = im_w[ACC_W] ? $unsigned(-im_w) : $unsigned(im_w);
        sum     = {1'b0, abs_re} + {1'b0, abs_im};
        shifted = sum >> SHIFT;
        if (|shifted[SUM_W-1:OUT_W]) begin
            mag_sat = '1;
        end else begin
            mag_sat = shifted[OUT_W-1:0];
        end
    end

    assign accept = valid_in && ready;

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: begin
                if (accept && idx == 5'd31) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (dcnt == 2'd3) begin
                    state_next = OUTPUT;
                end
            end
            OUTPUT:  state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= COLLECT;
            ready     <= 1'b0;
            idx       <= '0;
            dcnt      <= '0;
            s1_v      <= 1'b0;
            s1_first  <= 1'b0;
            s1_x      <= '0;
            s1_n      <= '0;
            s2_v      <= 1'b0;
            s2_first  <= 1'b0;
            s2_re     <= '0;
            s2_im     <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            mag_q     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == COLLECT);
            dcnt  <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
            if (accept) begin
                idx <= idx + 5'd1;
            end

            s1_v     <= accept;
            s1_first <= (idx == 5'd0);
            s1_n     <= idx;
            if (accept) begin
                s1_x <= $signed(data_in);
            end

            s2_v     <= s1_v;
            s2_first <= s1_first;
            if (s1_v) begin
                s2_re <= x_ext * c_ext;
                s2_im <= x_ext * s_ext;
            end

            // The first product of a chunk overwrites the running sums.
            if (s2_v) begin
                if (s2_first) begin
                    acc_re <= ACC_W'(s2_re);
                    acc_im <= -ACC_W'(s2_im);
                end else begin
                    acc_re <= acc_re + ACC_W'(s2_re);
                    acc_im <= acc_im - ACC_W'(s2_im);
                end
            end

            mag_q     <= mag_sat;
            valid_out <= (state_next == OUTPUT);
            if (state_next == OUTPUT) begin
                data_out <= mag_q;
            end
        end
    end

endmodule

// File: tb/tb_dft_bin_mag.sv
// Randomized scoreboard bench for dft_bin_mag.
// Expected magnitudes come from a real-arithmetic DFT model.
module tb_dft_bin_mag;

    localparam int DATA_W = 12;
    localparam int OUT_W  = 15;
    localparam int BIN    = 2;
    localparam int TW_W   = 12;
    localparam int SHIFT  = 12;
    localparam real PI    = 3.14159265358979;

    logic              tb_clk = 1'b0;
    logic              rst_n  = 1'b0;
    logic [DATA_W-1:0] data_in  = '0;
    logic              valid_in = 1'b0;
    logic              ready;
    logic [OUT_W-1:0]  data_out;
    logic              valid_out;

    always #5 tb_clk = ~tb_clk;

    dft_bin_mag #(
        .DATA_W(DATA_W),
        .OUT_W (OUT_W),
        .BIN   (BIN),
        .TW_W  (TW_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk      (tb_clk),
        .rst      (rst_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready),
        .data_out (data_out),
        .valid_out(valid_out)
    );

    typedef struct {
        int    exp;
        int    lo;
        int    hi;
        string name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pushed = 0;
    int   pulses = 0;

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_range(input string name, input int act,
                             input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi($floor(r + 0.5));
        return -$rtoi($floor(-r + 0.5));
    endfunction

    function automatic int model(input int xs[32]);
        longint re = 0;
        longint im = 0;
        longint m;
        for (int n = 0; n < 32; n++) begin
            real ang = 2.0 * PI * BIN * n / 32.0;
            re += longint'(xs[n]) * rnd(1024.0 * $cos(ang));
            im -= longint'(xs[n]) * rnd(1024.0 * $sin(ang));
        end
        if (re < 0) re = -re;
        if (im < 0) im = -im;
        m = (re + im) >> SHIFT;
        if (m > (1 << OUT_W) - 1) m = (1 << OUT_W) - 1;
        return int'(m);
    endfunction

    task automatic summary_and_fatal(input string why);
        miscompares++;
        $display("FAIL %s: bound expired", why);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $fatal(1, "aborted");
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_sample(input int x, input bit gaps);
        int t;
        if (gaps && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
                valid_in = 1'b0;
                data_in  = DATA_W'($urandom);
                @(negedge tb_clk);
            end
        end
        valid_in = 1'b1;
        data_in  = DATA_W'(x);
        t = 0;
        while (!ready) begin
            @(negedge tb_clk);
            t++;
            if (t > 100) summary_and_fatal("ready_timeout");
        end
        @(negedge tb_clk);
    endtask

    task automatic send_chunk(input int xs[32], input bit gaps,
                              input string name, input int lo, input int hi);
        exp_t e;
        for (int n = 0; n < 32; n++) begin
            send_sample(xs[n], gaps);
        end
        valid_in = 1'b0;
        e.exp  = model(xs);
        e.lo   = lo;
        e.hi   = hi;
        e.name = name;
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor: tracks acceptances and checks the handshake window and outputs.
    int      idx = 0;
    int      since = 0;
    bit      acc;
    bit      rst_s;
    bit      prev_rst = 1'b1;
    int      last_out = 0;
    exp_t    got;

    initial begin
        forever begin
            @(posedge tb_clk);
            acc   = rst_n && valid_in && ready;
            rst_s = rst_n;
            if (!rst_s) begin
                idx   = 0;
                since = 0;
            end else begin
                if (since != 0) since = (since >= 6) ? 0 : since + 1;
                if (acc) begin
                    if (idx == 31) begin
                        idx   = 0;
                        since = 1;
                    end else begin
                        idx++;
                    end
                end
            end
            #1;
            if (!rst_s) begin
                chk("reset_ready", int'(ready), 0);
                chk("reset_valid_out", int'(valid_out), 0);
                chk("reset_data_out", int'(data_out), 0);
            end else begin
                if (prev_rst) chk("ready_after_reset", int'(ready), 1);
                if (since >= 1 && since <= 5) chk("ready_low_window", int'(ready), 0);
                if (since == 6) begin
                    chk("ready_reopen", int'(ready), 1);
                    chk("data_out_hold", int'(data_out), last_out);
                end
                if (valid_out || since == 5) begin
                    chk("valid_out_timing", int'(valid_out), int'(since == 5));
                end
                if (valid_out) begin
                    pulses++;
                    last_out = int'(data_out);
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        got = sb.pop_front();
                        chk(got.name, int'(data_out), got.exp);
                        if (got.lo <= got.hi) begin
                            chk_range({got.name, "_range"}, int'(data_out),
                                      got.lo, got.hi);
                        end
                    end
                end
            end
            prev_rst = !rst_s;
        end
    end

    int xs[32];
    int t;

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        repeat (3) @(negedge tb_clk);
        rst_n = 1'b1;
        @(negedge tb_clk);

        for (int n = 0; n < 32; n++) xs[n] = 100;
        send_chunk(xs, 1'b0, "dc", 0, 0);

        for (int n = 0; n < 32; n++)
            xs[n] = rnd(1000.0 * $cos(2.0 * PI * 2 * n / 32.0));
        send_chunk(xs, 1'b0, "cosine", 3999, 4001);

        for (int n = 0; n < 32; n++)
            xs[n] = rnd(1000.0 * $sin(2.0 * PI * 2 * n / 32.0));
        send_chunk(xs, 1'b0, "sine", 3999, 4001);

        for (int n = 0; n < 32; n++) xs[n] = 0;
        xs[0] = 2047;
        send_chunk(xs, 1'b0, "impulse", 511, 511);

        repeat (8) @(negedge tb_clk);
        for (int n = 0; n < 10; n++) send_sample(123 * n - 600, 1'b1);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge tb_clk);
        rst_n = 1'b1;
        @(negedge tb_clk);
        for (int n = 0; n < 32; n++)
            xs[n] = rnd(1000.0 * $cos(2.0 * PI * 2 * n / 32.0));
        send_chunk(xs, 1'b0, "cosine_after_reset", 3999, 4001);

        for (int c = 0; c < 256; c++) begin
            int kind = $urandom_range(0, 7);
            for (int n = 0; n < 32; n++) begin
                if (kind == 0) xs[n] = 2047;
                else if (kind == 1) xs[n] = -2048;
                else if (kind == 2)
                    xs[n] = (((BIN * n) % 32) < 16) ? 2047 : -2048;
                else xs[n] = int'($urandom_range(0, 4095)) - 2048;
            end
            send_chunk(xs, 1'b1, "random_chunk", 1, 0);
        end

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge tb_clk);
            t++;
        end
        repeat (4) @(negedge tb_clk);
        chk("outputs_drained", sb.size(), 0);
        chk("pulse_count", pulses, pushed);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
